dds_phase_streamer: RTL
=======================

DDS_PHASE_STREAMER -- requirements
Module: dds_phase_streamer

Interface
REQ-001 Parameter PHASE_W, default 16, sets the phase word and tdata width.
REQ-002 Parameter CNT_W, default 16, sets the burst-count width.
REQ-003 aclk  in  1  single clock; all logic rising-edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 cfg_valid  in  1  one-cycle strobe; loads cfg_pinc, cfg_poff and cfg_count into shadow registers.
REQ-006 cfg_pinc  in  PHASE_W  phase increment per beat.
REQ-007 cfg_poff  in  PHASE_W  start phase.
REQ-008 cfg_count  in  CNT_W  beats per burst; 0 = continuous.
REQ-009 start  in  1  one-cycle strobe; begins a burst.
REQ-010 stop  in  1  one-cycle strobe; ends the stream after the current beat.
REQ-011 m_axis_phase_tdata  out  PHASE_W  phase word to the DDS S_AXIS_PHASE port.
REQ-012 m_axis_phase_tvalid  out  1  AXI-Stream valid.
REQ-013 m_axis_phase_tready  in  1  AXI-Stream ready from the DDS.
REQ-014 busy  out  1  high in the STREAM state.
REQ-015 done  out  1  one-cycle pulse after the final beat handshakes.

Function
REQ-016 The FSM shall have the states IDLE, STREAM and DONE; all outputs shall be registered.
REQ-017 IDLE -> STREAM on start: acc <= shadow poff; remaining <= shadow count; active pinc <= shadow pinc.
- tvalid rises on the cycle after start (latency 1).
REQ-018 In STREAM, tvalid shall be 1 and tdata shall equal acc.
REQ-019 A beat is tvalid & tready; on each beat:
- acc <= acc + pinc, modulo 2^PHASE_W (wrap, no saturation);
- remaining decrements when count != 0.
REQ-020 While tvalid & !tready, tdata shall hold stable and tvalid shall not deassert.
REQ-021 On the beat with remaining == 1 (count != 0), or the first beat at/after a stop request, the FSM shall go to DONE.
- tvalid = 0 in the following cycle.
REQ-022 DONE shall last one cycle with done = 1, then return to IDLE.
REQ-023 In STREAM, stop shall set a pending flag and shall not drop tvalid before the next beat; stop in IDLE or DONE shall be ignored.
REQ-024 start in STREAM or DONE shall be ignored.
REQ-025 cfg_valid in any state shall update the shadow registers only.
- In STREAM, a new pinc shall apply to the accumulator update of the first beat after the strobe.
- A new poff or count shall take effect at the next start.
REQ-026 If cfg_valid and start occur in the same cycle, start shall use the new cfg values.
REQ-027 If stop and the final counted beat coincide, there shall be a single DONE and a single done pulse.
REQ-028 Continuous mode (count 0) shall run until stop, with no limit on the number of beats.

Reset
REQ-029 On aresetn = 0 at a clock edge, the block shall enter IDLE.
- tvalid = 0, tdata = 0, busy = 0, done = 0.
- acc, remaining, the pending-stop flag and the shadow registers = 0.
REQ-030 Reset mid-stream shall drop tvalid on the next edge, with no done pulse.

Structure
REQ-031 A package dds_pkg shall hold:
- the FSM state enum (IDLE, STREAM, DONE);
- default PHASE_W and CNT_W;
- the typedef phase_t.
REQ-032 One sub-module, dds_phase_acc, is natural for the accumulator with load/enable and modulo wrap; everything else shall be in the top module.

Verification
REQ-033 Reset/idle: hold aresetn low for 5 cycles, then release -> all outputs 0 and tvalid stays 0 without start.
REQ-034 Burst: cfg pinc = 20, poff = 0, count = 4, start, tready = 1 -> tdata 0, 20, 40, 60 on consecutive cycles, then done pulse once and tvalid = 0.
REQ-035 Backpressure and wrap: pinc = 0x4000, poff = 0xC000, count = 3, tready toggling 1/0 -> tdata 0xC000, 0x0000, 0x4000, each held stable while tready = 0.
REQ-036 Stop in continuous mode: count = 0, pinc = 1, start, tready = 0 with stop pulsed -> tvalid stays high until tready = 1, exactly one more beat, then done.
REQ-037 Live cfg: streaming with pinc = 10; cfg_valid with pinc = 100 after beat 2 -> phase step becomes 100 from the next accumulator update.
REQ-038 Reset mid-burst: assert aresetn low during STREAM -> tvalid = 0 next cycle and no done pulse.

Source files
------------

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and defaults for the DDS phase streamer
package dds_pkg;

    localparam int DEF_PHASE_W = 16;
    localparam int DEF_CNT_W   = 16;

    typedef logic [DEF_PHASE_W-1:0] phase_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/dds_phase_streamer_if.sv
// rtl/dds_phase_streamer_if.sv - phase stream channel toward the DDS S_AXIS_PHASE port
// Signals: tdata (phase word), tvalid, tready.
// master: drives tdata/tvalid, samples tready. slave: the reverse.
interface dds_phase_streamer_if
    import dds_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W
) ();

    logic [PHASE_W-1:0] tdata;
    logic               tvalid;
    logic               tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/dds_phase_acc.sv
// rtl/dds_phase_acc.sv - phase accumulator with load and enable, wrapping modulo 2^W
// Ports: aclk, aresetn (sync, active-low), load/load_val (preset), en/inc (add step), acc (current phase).
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int W = DEF_PHASE_W
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] inc,
    output logic [W-1:0] acc
);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (en) begin
            // Natural overflow of the W-bit add gives the phase wrap.
            acc <= acc + inc;
        end
    end

endmodule

// File: rtl/dds_phase_streamer.sv
// rtl/dds_phase_streamer.sv - streams accumulated phase words to a DDS in counted or continuous bursts
// Ports: aclk, aresetn (sync, active-low); cfg_valid/cfg_pinc/cfg_poff/cfg_count (shadow config load);
//        start, stop (control strobes); m_axis_phase (phase stream master); busy, done (status).
module dds_phase_streamer
    import dds_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cfg_valid,
    input  logic [PHASE_W-1:0]   cfg_pinc,
    input  logic [PHASE_W-1:0]   cfg_poff,
    input  logic [CNT_W-1:0]     cfg_count,
    input  logic                 start,
    input  logic                 stop,
    dds_phase_streamer_if.master m_axis_phase,
    output logic                 busy,
    output logic                 done
);

    state_t             state;
    logic [PHASE_W-1:0] sh_pinc;
    logic [PHASE_W-1:0] sh_poff;
    logic [CNT_W-1:0]   sh_count;
    logic [PHASE_W-1:0] pinc_act;
    logic [CNT_W-1:0]   remaining;
    logic               stop_pend;
    logic               tvalid_r;
    logic [PHASE_W-1:0] acc;

    // A cfg strobe coinciding with start must be seen by that start,
    // so the live inputs bypass the shadow registers in that cycle.
    logic [PHASE_W-1:0] st_pinc;
    logic [PHASE_W-1:0] st_poff;
    logic [CNT_W-1:0]   st_count;
    logic               beat;
    logic               last_beat;
    logic               acc_load;

    assign st_pinc  = cfg_valid ? cfg_pinc  : sh_pinc;
    assign st_poff  = cfg_valid ? cfg_poff  : sh_poff;
    assign st_count = cfg_valid ? cfg_count : sh_count;

    assign beat     = tvalid_r & m_axis_phase.tready;
    // remaining only reaches 1 in counted mode; it sits at 0 when continuous.
    // A stop arriving on a beat cycle ends the stream on that beat.
    assign last_beat = (remaining == CNT_W'(1)) | stop_pend | stop;
    assign acc_load  = (state == IDLE) & start;

    dds_phase_acc #(.W(PHASE_W)) u_acc (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (acc_load),
        .load_val (st_poff),
        .en       ((state == STREAM) & beat),
        .inc      (pinc_act),
        .acc      (acc)
    );

    assign m_axis_phase.tdata  = acc;
    assign m_axis_phase.tvalid = tvalid_r;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            sh_pinc   <= '0;
            sh_poff   <= '0;
            sh_count  <= '0;
            pinc_act  <= '0;
            remaining <= '0;
            stop_pend <= 1'b0;
            tvalid_r  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (cfg_valid) begin
                sh_pinc  <= cfg_pinc;
                sh_poff  <= cfg_poff;
                sh_count <= cfg_count;
            end
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= st_count;
                        pinc_act  <= st_pinc;
                        stop_pend <= 1'b0;
                        tvalid_r  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    // A new step applies from the next beat's update onward.
                    if (cfg_valid) begin
                        pinc_act <= cfg_pinc;
                    end
                    if (beat) begin
                        if (remaining != '0) begin
                            remaining <= remaining - CNT_W'(1);
                        end
                        if (last_beat) begin
                            stop_pend <= 1'b0;
                            tvalid_r  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end else if (stop) begin
                        stop_pend <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
